// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-requester round-robin arbiter with a registered one-hot grant,
// a per-grant hold limit and one forced idle cycle after every release or timeout.
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 32'd16,
  parameter int unsigned HOLD_W   = 32'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic              HOLD_EN   = (MAX_HOLD != 32'd0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(32'd0);

  // Search ptr+1, ptr+2, ... wrapping, ending at ptr; first set bit wins.
  function automatic logic [3:0] rr_pick(input logic [15:0] req_v, input logic [3:0] ptr_v);
    logic [3:0] cand;
    logic [3:0] pick;
    logic       found;
    pick  = ptr_v;
    found = 1'b0;
    for (int i = 32'sd1; i <= 32'sd16; i++) begin
      cand  = ptr_v + 4'(i);
      pick  = (!found && req_v[cand]) ? cand : pick;
      found = found | req_v[cand];
    end
    return pick;
  endfunction

  function automatic logic [15:0] decode4(input logic [3:0] idx_v);
    logic [15:0] d;
    d        = 16'h0000;
    d[idx_v] = 1'b1;
    return d;
  endfunction

  state_t              state_r, state_s;
  logic [3:0]          ptr_r, ptr_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [15:0]         gnt_r, gnt_s;
  logic [3:0]          gnt_idx_r, gnt_idx_s;
  logic                gnt_valid_r, gnt_valid_s;
  logic                timeout_r, timeout_s;
  logic                release_s;
  logic [3:0]          winner_s;

  assign winner_s  = rr_pick(req, ptr_r);
  assign release_s = done | ~req[gnt_idx_r];

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = gnt_r;
    gnt_idx_s   = gnt_idx_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != 16'h0000) begin
          gnt_idx_s   = winner_s;
          gnt_s       = decode4(winner_s);
          gnt_valid_s = 1'b1;
          ptr_s       = winner_s;
          hold_cnt_s  = HOLD_ZERO;
          state_s     = GRANT;
        end else begin
          gnt_s       = 16'h0000;
          gnt_valid_s = 1'b0;
          state_s     = IDLE;
        end
      end
      GRANT: begin
        // Release wins over timeout; both leave a gap cycle in IDLE.
        if (release_s) begin
          gnt_s       = 16'h0000;
          gnt_valid_s = 1'b0;
          state_s     = IDLE;
        end else if (HOLD_EN && (hold_cnt_r == HOLD_LAST)) begin
          gnt_s       = 16'h0000;
          gnt_valid_s = 1'b0;
          timeout_s   = 1'b1;
          state_s     = IDLE;
        end else begin
          hold_cnt_s  = hold_cnt_r + HOLD_ONE;
          state_s     = GRANT;
        end
      end
      default: begin
        gnt_s       = 16'h0000;
        gnt_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 4'd15;
      hold_cnt_r  <= HOLD_ZERO;
      gnt_r       <= 16'h0000;
      gnt_idx_r   <= 4'd15;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_r       <= gnt_s;
      gnt_idx_r   <= gnt_idx_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed, table-driven bench for rr_arbiter_16 (hold limit set to 4) plus a
// hand-written full-rotation sequence.
module tb_rr_arbiter_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int total;
  int bad;

  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        valid;
    logic        tmo;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs[NV];

  rr_arbiter_16 #(.MAX_HOLD(32'd4), .HOLD_W(32'd8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input string name, input logic r, input logic [15:0] q, input logic d,
                      input logic [15:0] eg, input logic [3:0] ei, input logic ev, input logic et);
    rst_n = r;
    req   = q;
    done  = d;
    @(posedge clk);
    #1;
    total++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || timeout !== et) begin
      bad++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end
  endtask

  initial begin
    logic [15:0] one;
    int          k;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;

    // reset, single requester, done after 3 grant cycles
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 4'd15, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
    vecs[2]  = '{1'b1, 16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
    vecs[4]  = '{1'b1, 16'h0001, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
    // park ptr at 13, then wrap to 2 and skip to 8
    vecs[6]  = '{1'b1, 16'h2000, 1'b0, 16'h2000, 4'd13, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 16'h2000, 1'b1, 16'h0000, 4'd13, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0104, 1'b0, 16'h0004, 4'd2,  1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h0104, 1'b1, 16'h0000, 4'd2,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h0104, 1'b0, 16'h0100, 4'd8,  1'b1, 1'b0};
    vecs[11] = '{1'b1, 16'h0104, 1'b0, 16'h0100, 4'd8,  1'b1, 1'b0};
    vecs[12] = '{1'b1, 16'h0004, 1'b0, 16'h0000, 4'd8,  1'b0, 1'b0};
    // hold limit 4: four grant cycles, timeout pulse, re-grant
    vecs[13] = '{1'b1, 16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
    vecs[14] = '{1'b1, 16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
    vecs[15] = '{1'b1, 16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
    vecs[16] = '{1'b1, 16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
    vecs[17] = '{1'b1, 16'h0010, 1'b0, 16'h0000, 4'd4,  1'b0, 1'b1};
    vecs[18] = '{1'b1, 16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
    // release on the same edge the limit would fire: no timeout
    vecs[19] = '{1'b1, 16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
    vecs[20] = '{1'b1, 16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
    vecs[21] = '{1'b1, 16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
    vecs[22] = '{1'b1, 16'h0010, 1'b1, 16'h0000, 4'd4,  1'b0, 1'b0};
    vecs[23] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd4,  1'b0, 1'b0};
    // holder 5 drops its request, 9 takes over after the gap
    vecs[24] = '{1'b1, 16'h0220, 1'b0, 16'h0020, 4'd5,  1'b1, 1'b0};
    vecs[25] = '{1'b1, 16'h0200, 1'b0, 16'h0000, 4'd5,  1'b0, 1'b0};
    vecs[26] = '{1'b1, 16'h0200, 1'b0, 16'h0200, 4'd9,  1'b1, 1'b0};
    // get idx 7, reset mid-grant, restart from requester 0
    vecs[27] = '{1'b1, 16'h0080, 1'b0, 16'h0000, 4'd9,  1'b0, 1'b0};
    vecs[28] = '{1'b1, 16'h0080, 1'b0, 16'h0080, 4'd7,  1'b1, 1'b0};
    vecs[29] = '{1'b0, 16'h0080, 1'b0, 16'h0000, 4'd15, 1'b0, 1'b0};
    vecs[30] = '{1'b1, 16'h0081, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
    // other request bits change during a grant: no effect
    vecs[31] = '{1'b1, 16'h0083, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
    vecs[32] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].req, vecs[i].done,
           vecs[i].gnt, vecs[i].idx, vecs[i].valid, vecs[i].tmo);
    end

    // full rotation after reset: 0,1,...,15,0 with a gap cycle each time
    step("rot_reset", 1'b0, 16'hFFFF, 1'b0, 16'h0000, 4'd15, 1'b0, 1'b0);
    for (int g = 0; g < 17; g++) begin
      k   = g % 16;
      one = 16'h0001;
      step($sformatf("rot_grant%0d", g), 1'b1, 16'hFFFF, 1'b0, one << k, 4'(k), 1'b1, 1'b0);
      step($sformatf("rot_gap%0d", g), 1'b1, 16'hFFFF, 1'b1, 16'h0000, 4'(k), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- 16-requester round-robin arbiter that shares one resource and drives a registered one-hot grant vector.
- The grant vector is the 4-to-16 decode of the registered winner index.
- Sits between requesting agents and a shared resource. Each winner holds the grant until it releases, drops its request, or exceeds a hold limit.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held; 0 disables the limit.
- HOLD_W, 8: width of the hold counter; MAX_HOLD must be < 2^HOLD_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  16  per-requester request level; bit i = requester i.
- done  input  1  release strobe from the current grant holder; ignored when gnt_valid=0.
- gnt  output  16  one-hot grant; all-zero when no grant. Equals the 4-to-16 decode of gnt_idx when gnt_valid=1.
- gnt_idx  output  4  index of the current grant holder; holds its last value when gnt_valid=0.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - gnt=16'h0000, gnt_idx=4'd15, gnt_valid=0, timeout=0.
  - Internal last-winner pointer = 15, so requester 0 has highest priority first.
  - hold_cnt=0; state=IDLE.
  - Reset mid-grant drops the grant on the same edge.
- State IDLE:
  - If req != 0 at a posedge, pick the winner by searching indices ptr+1, ptr+2, … wrapping mod 16, ending at ptr. The first set bit wins.
  - Register the winner into gnt_idx/gnt, set gnt_valid=1, set ptr=winner, hold_cnt=0, go to GRANT.
  - Latency: req asserted before edge k produces a grant visible immediately after edge k.
  - If req == 0, stay in IDLE with outputs zero.
- State GRANT, evaluated each posedge:
  - Release: done=1, or req[gnt_idx]=0. Then gnt=0, gnt_valid=0, go to IDLE.
  - Timeout: MAX_HOLD != 0, no release, and hold_cnt == MAX_HOLD-1. Then gnt=0, gnt_valid=0, timeout=1 for exactly the next cycle, go to IDLE.
  - Otherwise: hold_cnt increments and the grant is unchanged.
  - Release takes precedence over timeout on the same edge; timeout stays 0 in that case.
- Gap cycle: every release or timeout is followed by at least one cycle with gnt_valid=0. Re-arbitration happens from IDLE on the following edge.
  - Consequence: with continuous requests, each grant lasts ≥1 cycle followed by exactly 1 idle cycle.
- Fairness:
  - ptr updates only when a grant is issued.
  - A timed-out or released holder becomes lowest priority in the next arbitration.
  - Any continuously-requesting agent is granted within 15 grants.
- Changes to req bits other than gnt_idx during GRANT have no effect until the next arbitration.
- Invariants:
  - gnt has at most one bit set.
  - gnt != 0 iff gnt_valid=1.
  - timeout=1 implies gnt_valid=0 in the same cycle.
- All outputs are registered; there is no combinational path from req or done to outputs.

Test Plan:
- Reset then req=16'h0001 held, done pulsed 3 cycles after the grant:
  - gnt=16'h0001 and gnt_idx=0 one edge after req.
  - Grant held 3 cycles; gnt=0 the edge after done.
- Round-robin rotation, req=16'hFFFF held, done pulsed each grant cycle:
  - gnt_idx sequence 0,1,2,…,15,0 with one gnt_valid=0 cycle between grants.
- Wrap and skip, ptr=13 (last winner 13), req=16'h0104:
  - Next grant idx 2 (search 14,15,0,1,2).
  - After release with the same req, next grant idx 8.
- Timeout, MAX_HOLD=4, req=16'h0010 held, done=0:
  - gnt=16'h0010 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle.
  - Re-grant of idx 4 the following edge.
  - Release-and-timeout on the same edge: timeout stays 0.
- Request drop, holder idx 5 deasserts req[5] with req[9] set:
  - gnt=0 next edge, then gnt=16'h0200 one edge later.
- Reset mid-grant, rst_n=0 while gnt_idx=7:
  - Next edge: gnt=0, gnt_valid=0, gnt_idx=15.
  - After rst_n=1 with req=16'h0081, first grant is idx 0.
